// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: result-select codes,
// forwarding-mux selects, controller FSM states and the forwarding rule.
package hazard_pkg;

  // Execute-stage result select
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  // ALU operand forwarding selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Memory-wait controller states
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } hz_state_t;

  // Pick the youngest in-flight producer of rs; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       wr_m,
    input logic [4:0] rd_w,
    input logic       wr_w
  );
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) return FWD_MEM;
    if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use bubble, branch
// flush, and a freeze FSM that holds the pipeline on data-memory wait with a
// sticky timeout. fsm_state exposes the controller state for observation.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             DmemReady,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic [1:0]       fsm_state
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  hz_state_t         state;
  hz_state_t         state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic              timeout_set;
  logic              lw_stall;
  logic              mem_wait;
  logic              hold;

  assign fsm_state = state;

  // Forwarding depends only on the current stage contents, never on the FSM.
  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  // Next-state and stall/flush decode. A memory wait freezes everything and
  // defers branch/load-use handling; reset masks the wait so stalls drop at once.
  always_comb begin
    lw_stall    = (ResultSrcE == RES_MEM) && (RdE != 5'd0) &&
                  ((RdE == Rs1D) || (RdE == Rs2D));
    mem_wait    = MemReqM && !DmemReady && !rst;
    state_next  = state;
    wait_next   = wait_cnt;
    timeout_set = 1'b0;
    hold        = 1'b0;
    StallF      = lw_stall && !PCSrcE;
    StallD      = lw_stall && !PCSrcE;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = PCSrcE;
    FlushE      = lw_stall || PCSrcE;
    FlushW      = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_wait) begin
          hold = 1'b1;
          if (TIMEOUT <= 1) begin
            state_next  = ERROR;
            timeout_set = 1'b1;
          end else begin
            state_next = MEM_WAIT;
            wait_next  = WAIT_W'(1);
          end
        end
      end
      MEM_WAIT: begin
        if (DmemReady) begin
          state_next = IDLE;
          wait_next  = '0;
        end else begin
          hold = 1'b1;
          if ((int'(wait_cnt) + 1) >= TIMEOUT) begin
            state_next  = ERROR;
            timeout_set = 1'b1;
          end else begin
            wait_next = wait_cnt + WAIT_W'(1);
          end
        end
      end
      ERROR: begin
        hold = 1'b1;
      end
      default: begin
        state_next = IDLE;
        wait_next  = '0;
      end
    endcase
    if (hold) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
    end
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      MemTimeout <= 1'b0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_next;
      MemTimeout <= MemTimeout | timeout_set;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (StallF),
    .count (StallCount)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (FlushD || FlushE),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl with a short timeout and narrow counters so that the
// timeout and saturation corners are reachable in a few cycles.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE, RegWriteM, RegWriteW, MemReqM, DmemReady;
  logic [1:0]       ForwardAE, ForwardBE, fsm_state;
  logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: wait cycles seen in the current freeze, error latch, counters.
  int m_wait = 0;
  bit m_err  = 1'b0;
  int m_scnt = 0;
  int m_fcnt = 0;

  // Clock.
  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .MemReqM    (MemReqM),
    .DmemReady  (DmemReady),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .MemTimeout (MemTimeout),
    .StallCount (StallCount),
    .FlushCount (FlushCount),
    .fsm_state  (fsm_state)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkc(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs)) return 2'b10;
    if (RegWriteW && (RdW != 5'd0) && (RdW == rs)) return 2'b01;
    return 2'b00;
  endfunction

  // Compare every output against the rule-level model, then advance the model
  // by the clock edge that follows.
  task automatic model_step();
    logic lw, waiting, frozen;
    logic e_stall, e_fd, e_fe;
    lw = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    if (rst) begin
      m_wait = 0;
      m_err  = 1'b0;
      m_scnt = 0;
      m_fcnt = 0;
    end
    waiting = !rst && !m_err && ((m_wait == 0) ? (MemReqM && !DmemReady) : !DmemReady);
    frozen  = m_err || waiting;
    e_stall = frozen ? 1'b1 : (lw && !PCSrcE);
    e_fd    = frozen ? 1'b0 : PCSrcE;
    e_fe    = frozen ? 1'b0 : (lw || PCSrcE);
    check1("StallF", StallF, e_stall);
    check1("StallD", StallD, e_stall);
    check1("StallE", StallE, frozen);
    check1("StallM", StallM, frozen);
    check1("FlushD", FlushD, e_fd);
    check1("FlushE", FlushE, e_fe);
    check1("FlushW", FlushW, frozen);
    check2("ForwardAE", ForwardAE, exp_fwd(Rs1E));
    check2("ForwardBE", ForwardBE, exp_fwd(Rs2E));
    check1("MemTimeout", MemTimeout, m_err);
    checkc("StallCount", StallCount, CNT_W'(m_scnt));
    checkc("FlushCount", FlushCount, CNT_W'(m_fcnt));
    if (!rst) begin
      if (e_stall && m_scnt < CNT_MAX) m_scnt++;
      if ((e_fd || e_fe) && m_fcnt < CNT_MAX) m_fcnt++;
      if (waiting) begin
        if (m_wait + 1 >= TIMEOUT) m_err = 1'b1;
        else m_wait++;
      end else if (!m_err) begin
        m_wait = 0;
      end
    end
  endtask

  // One clock: model compare at the falling edge, return just after rising edge.
  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
    RdM = 5'd0; RdW = 5'd0; ResultSrcE = 2'b00; PCSrcE = 1'b0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemReqM = 1'b0; DmemReady = 1'b0;
  endtask

  // Directed stimulus with literal expectations at the interesting points.
  initial begin
    clear_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    checkc("rst_stall_cnt", StallCount, 4'd0);
    check2("rst_state", fsm_state, IDLE);
    rst = 1'b0;

    // Forwarding priority and x0
    RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5; RdW = 5'd5; RegWriteW = 1'b1; Rs2E = 5'd0;
    #1;
    check2("fwdA_mem", ForwardAE, 2'b10);
    check2("fwdB_x0", ForwardBE, 2'b00);
    cycle();
    RdM = 5'd0;
    #1;
    check2("fwdA_wb", ForwardAE, 2'b01);
    cycle();
    Rs2E = 5'd5;
    #1;
    check2("fwdB_wb", ForwardBE, 2'b01);
    cycle();
    clear_inputs();

    // Load-use bubble
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    check1("lu_stallF", StallF, 1'b1);
    check1("lu_stallD", StallD, 1'b1);
    check1("lu_flushE", FlushE, 1'b1);
    check1("lu_flushD", FlushD, 1'b0);
    cycle();
    clear_inputs();
    #1;
    check1("lu_release", StallF, 1'b0);
    checkc("lu_scnt", StallCount, 4'd1);
    checkc("lu_fcnt", FlushCount, 4'd1);
    cycle();

    // Load-use with taken branch: flush wins
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
    #1;
    check1("lub_stallF", StallF, 1'b0);
    check1("lub_stallD", StallD, 1'b0);
    check1("lub_flushD", FlushD, 1'b1);
    check1("lub_flushE", FlushE, 1'b1);
    cycle();
    clear_inputs();
    #1;
    checkc("lub_fcnt", FlushCount, 4'd2);
    checkc("lub_scnt", StallCount, 4'd1);
    cycle();

    // Memory wait with taken branch: stall first, flush on ready
    MemReqM = 1'b1; DmemReady = 1'b0; PCSrcE = 1'b1;
    #1;
    check1("mwb_stallF", StallF, 1'b1);
    check1("mwb_stallM", StallM, 1'b1);
    check1("mwb_flushW", FlushW, 1'b1);
    check1("mwb_flushD", FlushD, 1'b0);
    check1("mwb_flushE", FlushE, 1'b0);
    cycle();
    DmemReady = 1'b1;
    #1;
    check1("mwb_rel_stallF", StallF, 1'b0);
    check1("mwb_rel_flushD", FlushD, 1'b1);
    check1("mwb_rel_flushE", FlushE, 1'b1);
    check1("mwb_rel_flushW", FlushW, 1'b0);
    check2("mwb_state", fsm_state, MEM_WAIT);
    cycle();
    clear_inputs();
    #1;
    check2("mwb_idle", fsm_state, IDLE);
    checkc("mwb_scnt", StallCount, 4'd2);
    checkc("mwb_fcnt", FlushCount, 4'd3);
    cycle();

    // Three wait cycles, ready on the fourth (the TIMEOUT-th) cycle
    MemReqM = 1'b1; DmemReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check1("w3_stallE", StallE, 1'b1);
      check1("w3_flushW", FlushW, 1'b1);
      cycle();
    end
    DmemReady = 1'b1;
    #1;
    check1("w3_rel_stallF", StallF, 1'b0);
    check1("w3_rel_stallM", StallM, 1'b0);
    check1("w3_rel_flushW", FlushW, 1'b0);
    cycle();
    clear_inputs();
    #1;
    check2("w3_idle", fsm_state, IDLE);
    check1("w3_no_timeout", MemTimeout, 1'b0);
    checkc("w3_scnt", StallCount, 4'd5);
    cycle();

    // Mixed vectors, checked by the model only
    for (int k = 0; k < 24; k++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      MemReqM    = 1'($urandom_range(0, 1));
      DmemReady  = 1'b1;
      cycle();
    end
    clear_inputs();

    // Saturation: 20 stalled cycles on a 4-bit counter
    ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
    repeat (20) cycle();
    clear_inputs();
    #1;
    checkc("sat_scnt", StallCount, 4'd15);
    checkc("sat_fcnt", FlushCount, 4'd15);
    cycle();

    // Timeout: ready never arrives
    MemReqM = 1'b1; DmemReady = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      #1;
      check1("to_pending", MemTimeout, 1'b0);
      check1("to_stallF", StallF, 1'b1);
      cycle();
    end
    #1;
    check2("to_state", fsm_state, ERROR);
    check1("to_flag", MemTimeout, 1'b1);
    MemReqM = 1'b0; DmemReady = 1'b1;
    #1;
    check1("err_stallF", StallF, 1'b1);
    check1("err_flushW", FlushW, 1'b1);
    cycle();
    cycle();
    check1("err_sticky", MemTimeout, 1'b1);

    // Asynchronous reset out of ERROR with a pending wait still presented
    MemReqM = 1'b1; DmemReady = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check1("ar_stallF", StallF, 1'b0);
    check1("ar_stallD", StallD, 1'b0);
    check1("ar_stallE", StallE, 1'b0);
    check1("ar_stallM", StallM, 1'b0);
    check1("ar_flushW", FlushW, 1'b0);
    check1("ar_timeout", MemTimeout, 1'b0);
    checkc("ar_scnt", StallCount, 4'd0);
    checkc("ar_fcnt", FlushCount, 4'd0);
    check2("ar_state", fsm_state, IDLE);
    cycle();
    clear_inputs();
    rst = 1'b0;
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core: drives the stall/enable and synchronous-clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB register banks and the ALU-operand forwarding muxes. It resolves RAW hazards by forwarding, load-use hazards by a one-cycle bubble and taken branches/jumps by flushing. A small FSM freezes the whole pipeline while a multi-cycle data memory is not ready, and flags a timeout. Saturating counters record stall and flush cycles for performance analysis.

## Interface
- TIMEOUT, 64: maximum consecutive data-memory wait cycles before the error flag.
- CNT_W, 32: width of the performance counters.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- Rs1D, Rs2D  in  5  source registers in Decode.
- Rs1E, Rs2E, RdE  in  5  sources and destination in Execute.
- ResultSrcE  in  2  Execute result select; 2'b01 = load.
- PCSrcE  in  1  branch taken or jump/jalr in Execute.
- RdM, RdW  in  5  destinations in Memory and Writeback.
- RegWriteM, RegWriteW  in  1  register-write enables in Memory and Writeback.
- MemReqM  in  1  load or store present in Memory.
- DmemReady  in  1  data memory completes the access this cycle.
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 10 Memory stage, 01 Writeback stage.
- StallF, StallD, StallE, StallM  out  1  hold PC / IF-ID / ID-EX / EX-MEM (enable = ~Stall).
- FlushD, FlushE, FlushW  out  1  synchronous clear of IF-ID / ID-EX / MEM-WB.
- MemTimeout  out  1  sticky error, data memory exceeded TIMEOUT wait cycles.
- StallCount, FlushCount  out  CNT_W  saturating performance counters.

## Operation
- Forwarding (per operand, A uses Rs1E, B uses Rs2E): 10 if RegWriteM && RdM!=0 && RdM==RsE; else 01 if RegWriteW && RdW!=0 && RdW==RsE; else 00. Memory stage wins over Writeback.
- lwStall = (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- FSM states IDLE, MEM_WAIT, ERROR.
- IDLE: memWait = MemReqM && !DmemReady. If memWait: go MEM_WAIT, wait counter = 1. Outputs in IDLE with no memWait: StallF = StallD = lwStall && !PCSrcE; FlushE = lwStall || PCSrcE; FlushD = PCSrcE; StallE = StallM = FlushW = 0.
- Any cycle with memWait (IDLE or MEM_WAIT): StallF = StallD = StallE = StallM = 1, FlushW = 1 (bubble into Writeback), FlushD = FlushE = 0; branch/load-use resolution is deferred, since the Execute instruction is held and re-evaluated after the wait.
- MEM_WAIT: DmemReady=1 returns to IDLE this cycle with IDLE outputs (no stall); else wait counter increments; reaching TIMEOUT goes ERROR.
- ERROR: all four stalls and FlushW held at 1, MemTimeout=1; left only by rst.
- StallCount increments on any cycle StallF=1; FlushCount on any cycle FlushD||FlushE; both saturate at all-ones.
- Forwarding is independent of FSM state.

## Timing
- Forward*, Stall*, Flush* combinational from inputs and registered state (same-cycle response).
- State, wait counter, MemTimeout, counters registered; counters visible one cycle after the counted event.
- Reset: state IDLE, wait counter 0, MemTimeout 0, StallCount 0, FlushCount 0; combinational outputs follow IDLE equations.
- Load-use: exactly one bubble; branch taken: exactly two flushed instructions (D, E).
- Simultaneous lwStall and PCSrcE: flush wins, no stall (PC must load target).
- Simultaneous memWait and PCSrcE: stall wins, flush occurs in the cycle DmemReady=1.
- TIMEOUT wait cycles exactly (cycle of entry counts as 1) before ERROR; DmemReady on cycle TIMEOUT still returns IDLE.
- rst mid-MEM_WAIT or ERROR: immediate return to IDLE, all stalls released asynchronously.

## Structure
- Shared package hazard_pkg: ResultSrc encodings (RES_ALU 00, RES_MEM 01, RES_PC4 10, RES_IMM 11), forward encodings (FWD_RF, FWD_MEM, FWD_WB), FSM state enum.
- One sub-module sat_counter (parameter width, inc, clk, rst) instantiated for StallCount and FlushCount.

## Test plan
- RdM=5, RegWriteM=1, Rs1E=5; RdW=5, RegWriteW=1 -> ForwardAE=10; RdM=0 same case -> ForwardAE=01; Rs2E=x0 always -> ForwardBE=00.
- ResultSrcE=01, RdE=7, Rs2D=7, PCSrcE=0 -> StallF=StallD=FlushE=1 one cycle, StallCount=1 next cycle.
- Same as above plus PCSrcE=1 -> StallF=StallD=0, FlushD=FlushE=1, FlushCount increments.
- MemReqM=1, DmemReady low 3 cycles then high -> all stalls and FlushW high 3 cycles, release on cycle 4, state IDLE, no MemTimeout.
- TIMEOUT=4, DmemReady held low -> ERROR after 4th wait cycle, MemTimeout=1 sticky; assert rst -> all outputs back to reset values same cycle.
- Force 2^CNT_W stall cycles (CNT_W=4 build) -> StallCount stops at 15.
